// File: rtl/cci_mpf_c0_rd_arb_pkg.sv
// Shared types and mdata ID-field helpers for the MPF c0 read arbiter.
package cci_mpf_c0_rd_arb_pkg;

   localparam int unsigned MPF_ARB_MAX_REQ = 8;
   localparam int unsigned CCI_CLADDR_W    = 42;
   localparam int unsigned CCI_MDATA_W     = 16;

   typedef logic [CCI_CLADDR_W-1:0] t_cci_clAddr;
   typedef logic [CCI_MDATA_W-1:0]  t_cci_mdata;

   typedef struct packed {
      t_cci_clAddr addr;
      t_cci_mdata  mdata;
   } t_c0tx_req;

   function automatic t_cci_mdata mdata_low_mask(int unsigned id_bits);
      return t_cci_mdata'(16'hFFFF >> id_bits);
   endfunction

   // Requester ID occupies the top id_bits of mdata.
   function automatic t_cci_mdata mdata_insert_id(logic [2:0] id, t_cci_mdata md,
                                                  int unsigned id_bits);
      return (t_cci_mdata'(id) << (CCI_MDATA_W - id_bits)) | (md & mdata_low_mask(id_bits));
   endfunction

   function automatic logic [3:0] mdata_extract_id(t_cci_mdata md, int unsigned id_bits);
      return 4'(md >> (CCI_MDATA_W - id_bits));
   endfunction

   function automatic t_cci_mdata mdata_restore(t_cci_mdata md, int unsigned id_bits);
      return md & mdata_low_mask(id_bits);
   endfunction

endpackage

// File: rtl/cci_mpf_c0_rd_arb_rr_arb.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i, with wrap.
module cci_mpf_rr_arb #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         elig_i,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] winner_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDX_W'((32'(rr_ptr_i) + 32'(i)) % NUM_REQ);
         if (!found && elig_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            winner_o     = idx;
         end
      end
   end

endmodule

// File: rtl/cci_mpf_c0_rd_arb.sv
// Round-robin arbiter sharing the MPF c0 read channel, with per-requester outstanding limits.
// Optional statistics counters are built when CCI_MPF_C0_RD_ARB_STATS_EN is defined.
module cci_mpf_c0_rd_arb
   import cci_mpf_c0_rd_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*42-1:0] req_addr,
   input  logic [NUM_REQ*16-1:0] req_mdata,
   output logic                  c0tx_valid,
   output logic [41:0]           c0tx_addr,
   output logic [15:0]           c0tx_mdata,
   input  logic                  c0TxAlmFull,
   input  logic                  c0rx_valid,
   input  logic [15:0]           c0rx_mdata,
   input  logic [511:0]          c0rx_data,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [15:0]           rsp_mdata,
   output logic [511:0]          rsp_data,
`ifdef CCI_MPF_C0_RD_ARB_STATS_EN
   output logic [NUM_REQ*32-1:0] stat_grants,
   output logic [31:0]           stat_almfull_cycles,
`endif
   output logic                  err_bad_id
);

   localparam int unsigned ID_BITS = $clog2(NUM_REQ);
   localparam int unsigned CNT_W   = 8;

   logic [NUM_REQ-1:0] elig_c, grant_c, inc_c, dec_c, rsp_valid_d, rsp_valid_q;
   logic [ID_BITS-1:0] winner_c, rr_ptr_d, rr_ptr_q;
   logic               grant_fire_c, rx_ok_c, rx_bad_c;
   logic [3:0]         rx_id_c;
   logic [CNT_W-1:0]   outstanding_d [NUM_REQ];
   logic [CNT_W-1:0]   outstanding_q [NUM_REQ];
   t_cci_clAddr        addr_c [NUM_REQ];
   t_cci_mdata         mdata_c [NUM_REQ];
   t_c0tx_req          c0tx_d, c0tx_q;
   logic               c0tx_valid_d, c0tx_valid_q;
   t_cci_mdata         rsp_mdata_d, rsp_mdata_q;
   logic [511:0]       rsp_data_d, rsp_data_q;
   logic               err_bad_id_d, err_bad_id_q;

   always_comb begin
      elig_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_c[i]  = req_addr[i*42 +: 42];
         mdata_c[i] = req_mdata[i*16 +: 16];
         elig_c[i]  = req_valid[i] && (outstanding_q[i] < CNT_W'(MAX_OUTSTANDING));
      end
   end

   cci_mpf_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
      .elig_i   (elig_c),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (grant_c),
      .winner_o (winner_c)
   );

   // Almost-full and reset both suppress the grant outright.
   assign grant_fire_c = (|grant_c) && !c0TxAlmFull && !reset;
   assign req_ready    = grant_fire_c ? grant_c : '0;

   assign rx_id_c  = mdata_extract_id(c0rx_mdata, ID_BITS);
   assign rx_ok_c  = c0rx_valid && (32'(rx_id_c) < NUM_REQ);
   assign rx_bad_c = c0rx_valid && !rx_ok_c;

   always_comb begin
      inc_c = '0;
      dec_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         inc_c[i] = grant_fire_c && (winner_c == ID_BITS'(i));
         dec_c[i] = rx_ok_c && (rx_id_c == 4'(i));
      end
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      c0tx_valid_d = grant_fire_c;
      c0tx_d       = c0tx_q;
      rsp_valid_d  = dec_c;
      rsp_mdata_d  = rsp_mdata_q;
      rsp_data_d   = rsp_data_q;
      err_bad_id_d = err_bad_id_q | rx_bad_c;
      if (grant_fire_c) begin
         rr_ptr_d     = ID_BITS'((32'(winner_c) + 32'd1) % NUM_REQ);
         c0tx_d.addr  = addr_c[winner_c];
         c0tx_d.mdata = mdata_insert_id(3'(winner_c), mdata_c[winner_c], ID_BITS);
      end
      if (rx_ok_c) begin
         rsp_mdata_d = mdata_restore(c0rx_mdata, ID_BITS);
         rsp_data_d  = c0rx_data;
      end
      // Simultaneous grant and response on one requester cancel; decrement saturates at zero.
      for (int i = 0; i < NUM_REQ; i++) begin
         outstanding_d[i] = outstanding_q[i];
         if (inc_c[i] && !dec_c[i]) begin
            outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
         end else if (dec_c[i] && !inc_c[i] && (outstanding_q[i] != '0)) begin
            outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         c0tx_valid_q <= 1'b0;
         c0tx_q       <= '0;
         rsp_valid_q  <= '0;
         rsp_mdata_q  <= '0;
         rsp_data_q   <= '0;
         err_bad_id_q <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            outstanding_q[i] <= '0;
         end
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         c0tx_valid_q  <= c0tx_valid_d;
         c0tx_q        <= c0tx_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_mdata_q   <= rsp_mdata_d;
         rsp_data_q    <= rsp_data_d;
         err_bad_id_q  <= err_bad_id_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign c0tx_valid = c0tx_valid_q;
   assign c0tx_addr  = c0tx_q.addr;
   assign c0tx_mdata = c0tx_q.mdata;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_mdata  = rsp_mdata_q;
   assign rsp_data   = rsp_data_q;
   assign err_bad_id = err_bad_id_q;

`ifdef CCI_MPF_C0_RD_ARB_STATS_EN
   logic [31:0] stat_grants_q [NUM_REQ];
   logic [31:0] stat_alm_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_alm_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants_q[i] <= '0;
         end
      end else begin
         if (c0TxAlmFull && (|req_valid)) begin
            stat_alm_q <= stat_alm_q + 32'd1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (inc_c[i]) begin
               stat_grants_q[i] <= stat_grants_q[i] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_grants[i*32 +: 32] = stat_grants_q[i];
      end
   end

   assign stat_almfull_cycles = stat_alm_q;
`endif

endmodule

// File: tb/tb_cci_mpf_c0_rd_arb.sv
// Scoreboard bench: dut_a (4 requesters, deep limit) for grant/route/reset, dut_b (3, limit 2) for limits and bad IDs.
`timescale 1ns/1ps
module tb_cci_mpf_c0_rd_arb;

   localparam int unsigned NA = 4;
   localparam int unsigned NB = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_reset, b_reset;

   logic [NA-1:0]    a_req_valid, a_req_ready, a_rsp_valid;
   logic [NA*42-1:0] a_req_addr;
   logic [NA*16-1:0] a_req_mdata;
   logic             a_tx_valid, a_almfull, a_rx_valid, a_err;
   logic [41:0]      a_tx_addr;
   logic [15:0]      a_tx_mdata, a_rx_mdata, a_rsp_mdata;
   logic [511:0]     a_rx_data, a_rsp_data;

   logic [NB-1:0]    b_req_valid, b_req_ready, b_rsp_valid;
   logic [NB*42-1:0] b_req_addr;
   logic [NB*16-1:0] b_req_mdata;
   logic             b_tx_valid, b_rx_valid, b_err;
   logic [41:0]      b_tx_addr;
   logic [15:0]      b_tx_mdata, b_rx_mdata, b_rsp_mdata;
   logic [511:0]     b_rsp_data;

`ifdef CCI_MPF_C0_RD_ARB_STATS_EN
   logic [NA*32-1:0] a_stat_grants;
   logic [31:0]      a_stat_alm;
   logic [NB*32-1:0] b_stat_grants;
   logic [31:0]      b_stat_alm;
`endif

   cci_mpf_c0_rd_arb #(.NUM_REQ(NA), .MAX_OUTSTANDING(64)) dut_a (
      .clk(clk), .reset(a_reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .req_mdata(a_req_mdata),
      .c0tx_valid(a_tx_valid), .c0tx_addr(a_tx_addr), .c0tx_mdata(a_tx_mdata),
      .c0TxAlmFull(a_almfull),
      .c0rx_valid(a_rx_valid), .c0rx_mdata(a_rx_mdata), .c0rx_data(a_rx_data),
      .rsp_valid(a_rsp_valid), .rsp_mdata(a_rsp_mdata), .rsp_data(a_rsp_data),
`ifdef CCI_MPF_C0_RD_ARB_STATS_EN
      .stat_grants(a_stat_grants), .stat_almfull_cycles(a_stat_alm),
`endif
      .err_bad_id(a_err)
   );

   cci_mpf_c0_rd_arb #(.NUM_REQ(NB), .MAX_OUTSTANDING(2)) dut_b (
      .clk(clk), .reset(b_reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .req_mdata(b_req_mdata),
      .c0tx_valid(b_tx_valid), .c0tx_addr(b_tx_addr), .c0tx_mdata(b_tx_mdata),
      .c0TxAlmFull(1'b0),
      .c0rx_valid(b_rx_valid), .c0rx_mdata(b_rx_mdata), .c0rx_data('0),
      .rsp_valid(b_rsp_valid), .rsp_mdata(b_rsp_mdata), .rsp_data(b_rsp_data),
`ifdef CCI_MPF_C0_RD_ARB_STATS_EN
      .stat_grants(b_stat_grants), .stat_almfull_cycles(b_stat_alm),
`endif
      .err_bad_id(b_err)
   );

   typedef struct {
      logic [41:0] addr;
      logic [15:0] mdata;
   } tx_t;

   typedef struct {
      logic [NA-1:0] vld;
      logic [15:0]   mdata;
      logic [511:0]  data;
   } rsp_t;

   tx_t  exp_tx[$];
   rsp_t exp_rsp[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic mon_en  = 1'b0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT output with nothing expected", name);
   endtask

   // Monitor pops the scoreboard whenever dut_a presents a request or response.
   always @(negedge clk) begin : mon
      tx_t  et;
      rsp_t er;
      if (mon_en) begin
         if (a_tx_valid) begin
            if (exp_tx.size() == 0) fail_now("tx_unexpected");
            else begin
               et = exp_tx.pop_front();
               check("tx_addr", 512'(a_tx_addr), 512'(et.addr));
               check("tx_mdata", 512'(a_tx_mdata), 512'(et.mdata));
            end
         end
         if (a_rsp_valid != '0) begin
            if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
            else begin
               er = exp_rsp.pop_front();
               check("rsp_valid", 512'(a_rsp_valid), 512'(er.vld));
               check("rsp_mdata", 512'(a_rsp_mdata), 512'(er.mdata));
               check("rsp_data", a_rsp_data, er.data);
            end
         end
      end
   end

   task automatic a_step(input logic [NA-1:0] exp_ready, output logic [NA-1:0] act);
      logic [15:0] md;
      @(negedge clk);
      act = a_req_ready;
      check("a_req_ready", 512'(a_req_ready), 512'(exp_ready));
      for (int k = 0; k < NA; k++) begin
         if (exp_ready[k]) begin
            md = a_req_mdata[k*16 +: 16];
            exp_tx.push_back('{addr: a_req_addr[k*42 +: 42], mdata: {2'(k), md[13:0]}});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic b_step(input logic [NB-1:0] exp_ready, input logic [NB-1:0] exp_rspv,
                         input logic [15:0] exp_md, input logic exp_err);
      @(negedge clk);
      check("b_req_ready", 512'(b_req_ready), 512'(exp_ready));
      check("b_rsp_valid", 512'(b_rsp_valid), 512'(exp_rspv));
      if (exp_rspv != '0) check("b_rsp_mdata", 512'(b_rsp_mdata), 512'(exp_md));
      check("b_err_bad_id", 512'(b_err), 512'(exp_err));
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [NA-1:0] act;
      int            cnt [NA];
      logic [511:0]  d;

      a_reset = 1'b1; b_reset = 1'b1;
      a_req_valid = '0; a_req_addr = '0; a_req_mdata = '0; a_almfull = 1'b0;
      a_rx_valid = 1'b0; a_rx_mdata = '0; a_rx_data = '0;
      b_req_valid = '0; b_req_addr = '0; b_req_mdata = '0;
      b_rx_valid = 1'b0; b_rx_mdata = '0;
      for (int k = 0; k < NA; k++) cnt[k] = 0;

      #22;
      check("rst_req_ready", 512'(a_req_ready), 512'(0));
      check("rst_tx_valid", 512'(a_tx_valid), 512'(0));
      check("rst_tx_addr", 512'(a_tx_addr), 512'(0));
      check("rst_tx_mdata", 512'(a_tx_mdata), 512'(0));
      check("rst_rsp_valid", 512'(a_rsp_valid), 512'(0));
      check("rst_rsp_mdata", 512'(a_rsp_mdata), 512'(0));
      check("rst_rsp_data", a_rsp_data, 512'(0));
      check("rst_err", 512'(a_err), 512'(0));
      @(posedge clk); #1;
      a_reset = 1'b0;
      mon_en  = 1'b1;

      // Single requester, three back-to-back reads.
      a_req_valid = 4'b0010;
      a_req_mdata[16 +: 16] = 16'hABCD;
      for (int j = 0; j < 3; j++) begin
         a_req_addr[42 +: 42] = 42'h100 + 42'(j);
         a_step(4'b0010, act);
      end
      a_req_valid = '0;
      a_step(4'b0000, act);

      // Mid-traffic async reset with rr_ptr at 3.
      for (int k = 0; k < NA; k++) begin
         a_req_addr[k*42 +: 42]  = 42'h200 + 42'(k);
         a_req_mdata[k*16 +: 16] = 16'hF010 + 16'(k);
      end
      a_req_valid = 4'b1111;
      a_step(4'b0100, act);
      #2 a_reset = 1'b1;
      #1;
      check("arst_req_ready", 512'(a_req_ready), 512'(0));
      check("arst_tx_valid", 512'(a_tx_valid), 512'(0));
      check("arst_tx_addr", 512'(a_tx_addr), 512'(0));
      check("arst_tx_mdata", 512'(a_tx_mdata), 512'(0));
      exp_tx.delete();
      @(posedge clk); #1;
      a_reset = 1'b0;

      // Fairness from reset: 100 grants rotating 0,1,2,3.
      for (int i = 0; i < 100; i++) begin
         a_step(4'b0001 << (i % 4), act);
         for (int k = 0; k < NA; k++) if (act[k]) cnt[k]++;
      end
      for (int k = 0; k < NA; k++) check("fair_count", 512'(cnt[k]), 512'(25));

      // Almost-full stall for five cycles; rotation resumes at held pointer.
      a_step(4'b0001, act);
      a_step(4'b0010, act);
      a_almfull = 1'b1;
      for (int i = 0; i < 5; i++) a_step(4'b0000, act);
      a_almfull = 1'b0;
      a_step(4'b0100, act);
      a_step(4'b1000, act);

      // Response routing with a simultaneous grant to requester 2.
      a_req_valid = 4'b0100;
      d = {16{32'hCAFE0001}};
      a_rx_valid = 1'b1; a_rx_mdata = 16'h8005; a_rx_data = d;
      exp_rsp.push_back('{vld: 4'b0100, mdata: 16'h0005, data: d});
      a_step(4'b0100, act);
      a_req_valid = '0;
      d = {8{64'h0123456789ABCDEF}};
      a_rx_mdata = 16'hC123; a_rx_data = d;
      exp_rsp.push_back('{vld: 4'b1000, mdata: 16'h0123, data: d});
      a_step(4'b0000, act);
      d = {64{8'h5A}};
      a_rx_mdata = 16'h3FFF; a_rx_data = d;
      exp_rsp.push_back('{vld: 4'b0001, mdata: 16'h3FFF, data: d});
      a_step(4'b0000, act);
      a_rx_valid = 1'b0;
      for (int i = 0; i < 3; i++) a_step(4'b0000, act);
      check("tx_queue_drained", 512'(exp_tx.size()), 512'(0));
      check("rsp_queue_drained", 512'(exp_rsp.size()), 512'(0));

      // dut_b: outstanding limit of 2, net no-op on simultaneous grant+response, bad ID.
      b_reset = 1'b0;
      b_req_valid = 3'b001;
      b_step(3'b001, 3'b000, 16'h0, 1'b0);
      b_rx_valid = 1'b1; b_rx_mdata = 16'h1234;
      b_step(3'b001, 3'b000, 16'h0, 1'b0);
      b_rx_valid = 1'b0;
      b_step(3'b001, 3'b001, 16'h1234, 1'b0);
      b_req_valid = 3'b111;
      b_step(3'b010, 3'b000, 16'h0, 1'b0);
      b_step(3'b100, 3'b000, 16'h0, 1'b0);
      b_step(3'b010, 3'b000, 16'h0, 1'b0);
      b_rx_valid = 1'b1; b_rx_mdata = 16'h0042;
      b_step(3'b100, 3'b000, 16'h0, 1'b0);
      b_rx_valid = 1'b0;
      b_step(3'b001, 3'b001, 16'h0042, 1'b0);
      b_rx_valid = 1'b1; b_rx_mdata = 16'hC000;
      b_step(3'b000, 3'b000, 16'h0, 1'b0);
      b_req_valid = 3'b000; b_rx_mdata = 16'h4007;
      b_step(3'b000, 3'b000, 16'h0, 1'b1);
      b_rx_valid = 1'b0;
      b_step(3'b000, 3'b010, 16'h0007, 1'b1);
      b_req_valid = 3'b010;
      b_step(3'b010, 3'b000, 16'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cci_mpf_c0_rd_arb.md
# cci_mpf_c0_rd_arb

Round-robin arbiter that shares the MPF c0 read-request channel among NUM_REQ independent requesters and routes c0 read responses back to the originator. It sits between client engines and the `to_fiu` side of an MPF interface, and drives the c0Tx request and c0Rx response fields. The requester ID travels in the high mdata bits. Per-requester outstanding-read limits prevent one client from monopolising FIU read credits.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..8; ID_BITS = $clog2(NUM_REQ).
- MAX_OUTSTANDING, 64: maximum in-flight reads per requester, legal range 1..255.

Ports:
- clk  in  1  interface clock; all logic is on this single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; a request transfers when valid and ready are both high.
- req_addr  in  NUM_REQ×42  cache-line addresses.
- req_mdata  in  NUM_REQ×16  client mdata; only the low 16-ID_BITS bits are preserved.
- c0tx_valid  out  1  read request to FIU.
- c0tx_addr  out  42  address forwarded to FIU.
- c0tx_mdata  out  16  {ID, client mdata low bits}.
- c0TxAlmFull  in  1  FIU flow control.
- c0rx_valid  in  1  read response from FIU.
- c0rx_mdata  in  16  mdata returned with the response.
- c0rx_data  in  512  response data.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_mdata  out  16  restored mdata; high ID_BITS bits are zero.
- rsp_data  out  512  response data.
- err_bad_id  out  1  sticky flag; set when a response carries an ID ≥ NUM_REQ.

## Operation
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Grant: when c0TxAlmFull=0, exactly one eligible requester is granted. The search starts at rr_ptr and proceeds in ascending index order with wrap-around. req_ready is one-hot (winner only) or all zero.
- When c0TxAlmFull=1, req_ready is all zero and no grant is made.
- After a grant to requester k, rr_ptr = (k+1) mod NUM_REQ. rr_ptr is unchanged on cycles with no grant.
- The accepted request is written into the c0tx output register with c0tx_mdata = {k[ID_BITS-1:0], req_mdata[k][15-ID_BITS:0]}.
- Outstanding counters: each is 8 bits wide. The counter increments on a grant and decrements on a routed response. A simultaneous increment and decrement on the same counter is a net no-op. Counters saturate at 0 and never underflow.
- Response routing: ID = c0rx_mdata[15:16-ID_BITS].
  - If ID < NUM_REQ, assert rsp_valid[ID] with the restored mdata and data.
  - Otherwise drop the response, set err_bad_id, and decrement no counter.
- err_bad_id clears only on reset.

## Timing
- Reset values:
  - req_ready = 0, c0tx_valid = 0, c0tx_addr = 0, c0tx_mdata = 0.
  - rsp_valid = 0, rsp_mdata = 0, rsp_data = 0, err_bad_id = 0.
  - rr_ptr = 0; all outstanding counters = 0.
- req_ready is combinational from req_valid, the counters, rr_ptr and c0TxAlmFull. It is forced to 0 while reset is high.
- Request latency: a grant in cycle N produces c0tx_valid=1 in cycle N+1, held for exactly one cycle. Throughput is one request per cycle.
- Response latency: c0rx_valid in cycle N produces rsp_valid in cycle N+1. The counter decrement is visible from cycle N+1.
- c0TxAlmFull is sampled in the same cycle as the grant decision. The FIU's almost-full slack absorbs the one request still held in the output register.
- Reset mid-operation clears the counters. Responses that arrive after reset are still routed by ID, and the decrement saturates at 0.

## Configuration
- CCI_MPF_C0_RD_ARB_STATS_EN defined:
  - Adds output stat_grants (NUM_REQ×32) with per-requester grant counts, wrapping at 2^32.
  - Adds output stat_almfull_cycles (32), which counts cycles where c0TxAlmFull=1 and any req_valid=1.
  - Both reset to 0.
- CCI_MPF_C0_RD_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package cci_mpf_c0_rd_arb_pkg holds:
  - t_cci_clAddr (42-bit address type);
  - the mdata ID-field helper functions (insert ID, extract ID, restore mdata);
  - the constant MPF_ARB_MAX_REQ = 8.
- One sub-module, cci_mpf_rr_arb: a parameterised NUM_REQ round-robin picker.
  - Inputs: eligibility vector and rr_ptr.
  - Outputs: one-hot grant and winner index.
  - Purely combinational; rr_ptr is owned by the parent.

## Test plan
- Single requester: requester 1 issues 3 back-to-back requests with addr 0x100..0x102 → c0tx_valid on 3 consecutive cycles with mdata[15:14]=1 (NUM_REQ=4); outstanding[1]=3.
- Fairness: all 4 requesters hold valid continuously from reset → grant order 0,1,2,3,0,1,… with each requester receiving exactly 25 of 100 grants.
- Almost-full: assert c0TxAlmFull for 5 cycles mid-stream → req_ready=0 for those 5 cycles; after deassertion, granting resumes at the held rr_ptr.
- Outstanding limit (MAX_OUTSTANDING=2): requester 0 issues 2 reads with no responses → requester 0 is masked while requesters 1..3 are still granted; one response with ID 0 → requester 0 becomes eligible the next cycle.
- Response routing: c0rx_mdata=0x8005 with NUM_REQ=4 → rsp_valid=4'b0100 and rsp_mdata=0x0005 one cycle later. A simultaneous grant to requester 2 leaves outstanding[2] unchanged.
- Bad ID and reset: NUM_REQ=3, response ID=3 → dropped and err_bad_id=1. Asynchronous reset pulse mid-traffic → all outputs 0 immediately and rr_ptr=0 after release.
